// File: rtl/instr_bus_responder.sv
// Instruction-memory slave for the MR1 fetch bus: in-order request queue, fixed-latency responses.
// Optional pseudo-random request stalls are enabled by defining STALL_INJECT_EN.
module instr_bus_responder #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned MEM_WORDS = 1024,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         instr_req_valid,
  output logic                         instr_req_ready,
  input  logic [31:0]                  instr_req_addr,
  output logic                         instr_rsp_valid,
  output logic [31:0]                  instr_rsp_data,
  input  logic                         load_valid,
  input  logic [$clog2(MEM_WORDS)-1:0] load_addr,
  input  logic [31:0]                  load_data,
  output logic                         addr_err
);

  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  localparam logic [TW-1:0] T_INIT   = TW'(LATENCY - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
  localparam logic [31:0]   NOP_WORD = 32'h0000_0013;

  if (DEPTH < 1 || LATENCY < 1 || LFSR_SEED == 16'h0000) begin : g_bad_param
    $error("instr_bus_responder: DEPTH and LATENCY must be >= 1 and LFSR_SEED nonzero");
  end

  logic [31:0]   mem_q [MEM_WORDS];

  logic [AW-1:0] idx_q   [DEPTH];
  logic          oor_q   [DEPTH];
  logic [TW-1:0] timer_q [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          rsp_valid_q;
  logic [31:0]   rsp_data_q;
  logic          addr_err_q;

  logic          stall;
  logic          push, pop;
  logic          req_oor, req_bad;

`ifdef STALL_INJECT_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR, taps 16,14,13,11
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // A pop in the same cycle does not make room; ready only looks at the registered count.
  assign instr_req_ready = (count_q < DEPTH_C) && !stall;

  always_comb begin
    push    = instr_req_valid && instr_req_ready;
    pop     = (count_q != '0) && (timer_q[head_q] == '0);
    req_oor = ({2'b00, instr_req_addr[31:2]} >= 32'(MEM_WORDS));
    req_bad = req_oor || (instr_req_addr[1:0] != 2'b00);

    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop) begin
      head_d = (head_q == PTR_LAST) ? '0 : head_q + 1'b1;
    end
    if (push) begin
      tail_d = (tail_q == PTR_LAST) ? '0 : tail_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      addr_err_q  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        idx_q[i]   <= '0;
        oor_q[i]   <= 1'b0;
        timer_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;

      // Free-running countdown on every slot; the slot being filled is overwritten below.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (timer_q[i] != '0) begin
          timer_q[i] <= timer_q[i] - 1'b1;
        end
      end

      if (push) begin
        idx_q[tail_q]   <= instr_req_addr[AW+1:2];
        oor_q[tail_q]   <= req_oor;
        timer_q[tail_q] <= T_INIT;
        if (req_bad) begin
          addr_err_q <= 1'b1;
        end
      end

      rsp_valid_q <= pop;
      if (pop) begin
        rsp_data_q <= oor_q[head_q] ? NOP_WORD : mem_q[idx_q[head_q]];
      end
    end
  end

  // Array is never reset; same-edge load and fetch read sees the old word.
  always_ff @(posedge clk) begin
    if (load_valid) begin
      mem_q[load_addr] <= load_data;
    end
  end

  assign instr_rsp_valid = rsp_valid_q;
  assign instr_rsp_data  = rsp_data_q;
  assign addr_err        = addr_err_q;

endmodule

// File: tb/tb_instr_bus_responder.sv
// Directed bench for instr_bus_responder: ordering, latency, backpressure, bad addresses, reset.
// Two instances: LATENCY=2/DEPTH=4 and LATENCY=4/DEPTH=2.
module tb_instr_bus_responder;

  logic        clk = 1'b0;
  logic        reset_n;

  logic        req_valid, req_ready, rsp_valid, ld_valid, addr_err;
  logic [31:0] req_addr, rsp_data, ld_data;
  logic [9:0]  ld_addr;

  logic        req_valid2, req_ready2, rsp_valid2, ld_valid2, addr_err2;
  logic [31:0] req_addr2, rsp_data2, ld_data2;
  logic [9:0]  ld_addr2;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  logic [31:0] exp_mem [4];
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  instr_bus_responder #(.DEPTH(4), .LATENCY(2), .MEM_WORDS(1024), .LFSR_SEED(16'hACE1)) u_dut (
    .clk(clk), .reset_n(reset_n),
    .instr_req_valid(req_valid), .instr_req_ready(req_ready), .instr_req_addr(req_addr),
    .instr_rsp_valid(rsp_valid), .instr_rsp_data(rsp_data),
    .load_valid(ld_valid), .load_addr(ld_addr), .load_data(ld_data),
    .addr_err(addr_err)
  );

  instr_bus_responder #(.DEPTH(2), .LATENCY(4), .MEM_WORDS(1024), .LFSR_SEED(16'hACE1)) u_dut2 (
    .clk(clk), .reset_n(reset_n),
    .instr_req_valid(req_valid2), .instr_req_ready(req_ready2), .instr_req_addr(req_addr2),
    .instr_rsp_valid(rsp_valid2), .instr_rsp_data(rsp_data2),
    .load_valid(ld_valid2), .load_addr(ld_addr2), .load_data(ld_data2),
    .addr_err(addr_err2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] exp, input string tag);
    chk({tag, "_rdy"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = a;
    tick();
    req_valid = 1'b0;
    chk({tag, "_v0"}, 32'(rsp_valid), 32'd0);
    tick();
    chk({tag, "_v1"}, 32'(rsp_valid), 32'd0);
    tick();
    chk({tag, "_v2"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_dat"}, rsp_data, exp);
  endtask

  initial begin
    int unsigned lo_cnt;
    logic [31:0] e;

    reset_n    = 1'b0;
    req_valid  = 1'b0; req_addr  = '0; ld_valid  = 1'b0; ld_addr  = '0; ld_data  = '0;
    req_valid2 = 1'b0; req_addr2 = '0; ld_valid2 = 1'b0; ld_addr2 = '0; ld_data2 = '0;
    exp_mem[0] = 32'h11; exp_mem[1] = 32'h22; exp_mem[2] = 32'h33; exp_mem[3] = 32'h44;

    tick();
    tick();
    reset_n = 1'b1;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_data",  rsp_data,       32'd0);
    chk("rst_err",   32'(addr_err),  32'd0);

    // Load both arrays.
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_addr = 10'(i); ld_data = exp_mem[i];
      ld_valid2 = (i == 0); ld_addr2 = '0; ld_data2 = 32'h0000_00AB;
      tick();
    end
    ld_valid = 1'b0; ld_valid2 = 1'b0;

    // Back-to-back fetches: responses on 4 consecutive cycles, 2 after first accept.
    for (int i = 0; i < 8; i++) begin
      req_valid = (i < 4);
      req_addr  = 32'(i) * 32'd4;
      if (i < 4) chk($sformatf("t1_rdy%0d", i), 32'(req_ready), 32'd1);
      tick();
      chk($sformatf("t1_v%0d", i), 32'(rsp_valid), (i >= 2 && i < 6) ? 32'd1 : 32'd0);
      if (i >= 2 && i < 6) chk($sformatf("t1_d%0d", i), rsp_data, exp_mem[i-2]);
    end
    req_valid = 1'b0;
    chk("t1_err", 32'(addr_err), 32'd0);

    // Read-before-write at the pop edge.
    req_valid = 1'b1; req_addr = 32'h8;
    tick();
    req_valid = 1'b0;
    tick();
    ld_valid = 1'b1; ld_addr = 10'd2; ld_data = 32'hDEAD;
    tick();
    ld_valid = 1'b0;
    chk("t4_v", 32'(rsp_valid), 32'd1);
    chk("t4_old", rsp_data, 32'h33);
    exp_mem[2] = 32'hDEAD;
    fetch(32'h8, 32'hDEAD, "t4_new");

    // Out-of-range and misaligned fetches.
    fetch(32'h1000, 32'h13, "t3_oor");
    chk("t3_err", 32'(addr_err), 32'd1);
    fetch(32'h4, 32'h22, "t3_good");
    chk("t3_sticky", 32'(addr_err), 32'd1);
    fetch(32'h5, 32'h22, "t3_mis");

    // Reset mid-flight.
    req_valid = 1'b1; req_addr = 32'h0;
    tick();
    req_addr = 32'h4;
    tick();
    req_addr = 32'h8;
    tick();
    req_valid = 1'b0;
    chk("t5_pre_v", 32'(rsp_valid), 32'd1);
    chk("t5_pre_d", rsp_data, 32'h11);
    #1 reset_n = 1'b0;
    #1;
    chk("t5_rst_v",   32'(rsp_valid), 32'd0);
    chk("t5_rst_d",   rsp_data,       32'd0);
    chk("t5_rst_err", 32'(addr_err),  32'd0);
    chk("t5_rst_rdy", 32'(req_ready), 32'd1);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t5_stale%0d", i), 32'(rsp_valid), 32'd0);
    end
    fetch(32'hC, 32'h44, "t5_new");

    // Continuous requests with in-order scoreboard.
    lo_cnt = 0;
    for (int k = 0; k < 1000; k++) begin
      req_valid = 1'b1;
      req_addr  = 32'(k % 4) * 32'd4;
      if (req_ready) sb.push_back(exp_mem[k % 4]);
      else lo_cnt++;
`ifndef STALL_INJECT_EN
      chk($sformatf("t6_rdy%0d", k), 32'(req_ready), 32'd1);
`endif
      tick();
      if (rsp_valid) begin
        e = (sb.size() != 0) ? sb.pop_front() : 32'hBAD0_BAD0;
        chk($sformatf("t6_d%0d", k), rsp_data, e);
      end
    end
    req_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (rsp_valid) begin
        e = (sb.size() != 0) ? sb.pop_front() : 32'hBAD0_BAD0;
        chk($sformatf("t6_drain%0d", k), rsp_data, e);
      end
    end
    chk("t6_left", 32'(sb.size()), 32'd0);
`ifdef STALL_INJECT_EN
    chk("t6_rate", 32'(lo_cnt >= 150 && lo_cnt <= 350), 32'd1);
`else
    chk("t6_nolo", 32'(lo_cnt), 32'd0);
`endif

    // LATENCY=4, DEPTH=2 with valid held high: 2 accepts / 2 responses per 5 cycles.
    for (int k = 0; k < 15; k++) begin
      req_valid2 = 1'b1;
      req_addr2  = 32'h0;
`ifndef STALL_INJECT_EN
      chk($sformatf("t2_rdy%0d", k), 32'(req_ready2), ((k % 5) < 2) ? 32'd1 : 32'd0);
`endif
      tick();
`ifndef STALL_INJECT_EN
      chk($sformatf("t2_v%0d", k), 32'(rsp_valid2),
          ((k % 5) == 4 || ((k % 5) == 0 && k > 0)) ? 32'd1 : 32'd0);
`endif
      if (rsp_valid2) chk($sformatf("t2_d%0d", k), rsp_data2, 32'hAB);
    end
    req_valid2 = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
